// File: rtl/float_recip_nr_if.sv
// Operand/result valid-ready handshake bundle for float_recip_nr.
interface float_recip_nr_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/float_recip_nr.sv
// Iterative float reciprocal: linear seed refined by Newton-Raphson on one shared multiplier.
// Define FLOAT_RECIP_NR_ROUND_EN to round the packed mantissa half-up instead of truncating it.
module float_recip_nr #(
    parameter int MANTISSA_SIZE = 23,
    parameter int ITERATIONS    = 3
) (
    input logic             clk,
    input logic             resetn,
    input logic             ce,
    float_recip_nr_if.slave bus
);
    localparam int M  = MANTISSA_SIZE;
    localparam int W  = 9 + M;
    localparam int F  = M + 4;
    localparam int QW = F + 2;

    localparam logic [63:0]   C48_FULL = (64'd48 << F) / 64'd17;
    localparam logic [63:0]   C32_FULL = (64'd32 << F) / 64'd17;
    localparam logic [QW-1:0] C48      = C48_FULL[QW-1:0];
    localparam logic [QW-1:0] C32      = C32_FULL[QW-1:0];
    localparam logic [QW-1:0] ONE      = {2'b01, {F{1'b0}}};
    localparam logic [QW-1:0] TWO      = {2'b10, {F{1'b0}}};
    localparam logic [QW-1:0] YMAX     = {2'b01, {M{1'b1}}, 4'b0000};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEED   = 3'd1;
    localparam logic [2:0] S_ITER_A = 3'd2;
    localparam logic [2:0] S_ITER_B = 3'd3;
    localparam logic [2:0] S_PACK   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [2:0] ITER_LAST = 3'(ITERATIONS - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [W-1:0]    out_q, out_d;
    logic            sign_q, sign_d;
    logic [7:0]      exp_q, exp_d;
    logic [M-1:0]    frac_q, frac_d;
    logic [QW-1:0]   y_q, y_d;
    logic [QW-1:0]   t_q, t_d;
    logic [QW-1:0]   d_op, mul_a, mul_b, prod_fx;
    logic [2*QW-1:0] prod;

    // y in [1, 2) maps onto the mantissa; 4 guard bits sit below it.
    function automatic logic [M-1:0] clamp_round(input logic [QW-1:0] y);
        logic [QW-1:0] yc;
`ifdef FLOAT_RECIP_NR_ROUND_EN
        logic [M:0] m_ext;
`endif
        yc = y;
        if (yc < ONE)
            yc = ONE;
        else if (yc > YMAX)
            yc = YMAX;
`ifdef FLOAT_RECIP_NR_ROUND_EN
        m_ext = {1'b0, yc[F-1 -: M]} + {{M{1'b0}}, yc[3]};
        if (m_ext[M])
            return {M{1'b1}};
        return m_ext[M-1:0];
`else
        return yc[F-1 -: M];
`endif
    endfunction

    function automatic logic [W-1:0] pack(input logic s, input logic [7:0] e,
                                          input logic [M-1:0] f, input logic [QW-1:0] y);
        logic [W-1:0] r;
        if (e == 8'hFF && f != '0)
            r = {1'b0, 8'hFF, 1'b1, {(M-1){1'b0}}};
        else if (e == 8'hFF)
            r = {s, {(W-1){1'b0}}};
        else if (e == 8'h00)
            r = {s, 8'hFF, {M{1'b0}}};
        else if (f == '0)
            r = (e == 8'd254) ? {s, {(W-1){1'b0}}} : {s, 8'd254 - e, {M{1'b0}}};
        else if (e >= 8'd253)
            r = {s, {(W-1){1'b0}}};
        else
            r = {s, 8'd253 - e, clamp_round(y)};
        return r;
    endfunction

    assign d_op          = {2'b00, 1'b1, frac_q, 3'b000};
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = out_q;

    // Single shared multiplier: 32/17*d in SEED, d*y in ITER_A, y*t in ITER_B.
    always_comb begin
        mul_a = d_op;
        mul_b = y_q;
        case (state_q)
            S_SEED: begin
                mul_a = C32;
                mul_b = d_op;
            end
            S_ITER_B: begin
                mul_a = y_q;
                mul_b = t_q;
            end
            default: begin
                mul_a = d_op;
                mul_b = y_q;
            end
        endcase
    end

    assign prod    = {{QW{1'b0}}, mul_a} * {{QW{1'b0}}, mul_b};
    assign prod_fx = prod[F +: QW];

    logic unused_prod;
    assign unused_prod = ^{prod[F-1:0], prod[2*QW-1:F+QW]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        y_d     = y_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_data[W-1];
                    exp_d   = bus.in_data[W-2 -: 8];
                    frac_d  = bus.in_data[M-1:0];
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                y_d     = C48 - prod_fx;
                cnt_d   = 3'd0;
                state_d = S_ITER_A;
            end
            S_ITER_A: begin
                t_d     = TWO - prod_fx;
                state_d = S_ITER_B;
            end
            S_ITER_B: begin
                y_d     = prod_fx;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == ITER_LAST) ? S_PACK : S_ITER_A;
            end
            S_PACK: begin
                out_d   = pack(sign_q, exp_q, frac_q, y_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            out_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Operand and iterate registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (ce) begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            frac_q <= frac_d;
            y_q    <= y_d;
            t_q    <= t_d;
        end
    end
endmodule

// File: tb/tb_float_recip_nr.sv
// Directed and random bench for float_recip_nr against a real-arithmetic reciprocal model.
module tb_float_recip_nr;
    localparam int M    = 23;
    localparam int W    = 32;
    localparam int ITER = 3;
    localparam int LAT  = 2*ITER + 2;
`ifdef FLOAT_RECIP_NR_ROUND_EN
    localparam int ULP = 1;
`else
    localparam int ULP = 2;
`endif
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic resetn;
    logic ce;
    int   n_chk = 0;
    int   n_pass = 0;
    int   overlap = 0;

    float_recip_nr_if #(.DATA_W(W)) bus ();

    float_recip_nr #(.MANTISSA_SIZE(M), .ITERATIONS(ITER)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ce     (ce),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (resetn === 1'b1 && bus.in_ready === 1'b1 && bus.out_valid === 1'b1)
            overlap++;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_ulp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int diff;
        diff = int'(obs) - int'(exp);
        if (diff < 0) diff = -diff;
        n_chk++;
        assert ((diff <= ULP) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %h expected %h within %0d ulp", tag, obs, exp, ULP);
    endtask

    // Reference: special cases by rule, otherwise 1/x = (2/1.f) * 2^(126-e) in real arithmetic.
    function automatic bit model_ok(input logic [31:0] x, input logic [31:0] r);
        logic        s;
        int          e;
        int          f;
        real         ideal, err;
        s = x[31];
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        if (e == 255 && f != 0) return r === 32'h7FC0_0000;
        if (e == 255)           return r === {s, 31'b0};
        if (e == 0)             return r === {s, 8'hFF, 23'b0};
        if (f == 0)             return (e == 254) ? (r === {s, 31'b0}) : (r === {s, 8'(254 - e), 23'b0});
        if (e >= 253)           return r === {s, 31'b0};
        if (r[31] !== s || r[30:23] !== 8'(253 - e)) return 1'b0;
        ideal = (2.0 / (1.0 + real'(f) / 8388608.0) - 1.0) * 8388608.0;
        err   = real'(int'(r[22:0])) - ideal;
        if (err < 0.0) err = -err;
        return err <= real'(ULP);
    endfunction

    task automatic run_op(input logic [31:0] x, input int ce_at,
                          output logic [31:0] res, output int lat, output bit rdy_seen);
        int n;
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            if (bus.in_ready === 1'b1) rdy_seen = 1'b1;
            if (lat == ce_at)     ce = 1'b0;
            if (lat == ce_at + 3) ce = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        ce  = 1'b1;
        res = bus.out_data;
    endtask

    logic [31:0] res, res3, held, x;
    int          lat;
    bit          rdy;
    logic [31:0] sp_in  [5] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC1_2345, 32'h7F00_0000};
    logic [31:0] sp_exp [5] = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000};

    initial begin
        resetn        = 1'b0;
        ce            = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", bus.out_data, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        run_op(32'h3F80_0000, -1, res, lat, rdy);
        check("one_result", res, 32'h3F80_0000);
        check("one_latency", 32'(lat), 32'(LAT));
        check("one_in_ready_low", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        check("one_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("one_out_valid_after", 32'(bus.out_valid), 32'd0);

        run_op(32'h4040_0000, -1, res3, lat, rdy);
        check_ulp("three", res3, 32'h3EAA_AAAB);
        run_op(32'hC080_0000, -1, res, lat, rdy);
        check("minus_four", res, 32'hBE80_0000);

        for (int i = 0; i < 5; i++) begin
            run_op(sp_in[i], -1, res, lat, rdy);
            check($sformatf("special_%h", sp_in[i]), res, sp_exp[i]);
            check($sformatf("special_lat_%h", sp_in[i]), 32'(lat), 32'(LAT));
        end

        // Backpressure: result must stay put while the consumer stalls.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op(32'h40A0_0000, -1, held, lat, rdy);
        check_ulp("five", held, 32'h3E4C_CCCD);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_stable", bus.out_data, held);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

        run_op(32'h4040_0000, 1, res, lat, rdy);
        check("ce_result", res, res3);
        check("ce_latency", 32'(lat), 32'(LAT + 3));

        // Abort an operation in ITER_B with an asynchronous reset.
        @(posedge clk); #1;
        bus.in_data  = 32'h40E0_0000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #2;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("abort_no_stale", 32'(bus.out_valid), 32'd0);
        run_op(32'h4000_0000, -1, res, lat, rdy);
        check("two_result", res, 32'h3F00_0000);
        check("two_latency", 32'(lat), 32'(LAT));

        for (int i = 0; i < NRAND; i++) begin
            x = {1'($urandom()), 8'($urandom_range(1, 254)), 23'($urandom())};
            run_op(x, -1, res, lat, rdy);
            n_chk++;
            assert (model_ok(x, res) === 1'b1) n_pass++;
            else $error("FAIL rand: in %h observed %h expected 1/x within %0d ulp (latency %0d)", x, res, ULP, lat);
        end

        check("no_ready_valid_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
